serial_subtractor_ctrl: RTL and testbench

SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

---
 rtl/serial_subtractor_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor (a - b - bin), LSB first, through one full-subtractor stage.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_BIT = 6'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_reg, diff_reg;
    logic [WIDTH-1:0] res_shift;
    logic [5:0]       cnt_reg;
    logic             br_reg, bout_reg;
    logic             x_bit, y_bit, d_bit, br_next;
    logic             accept, last_bit;

    assign x_bit    = a_sh_reg[0];
    assign y_bit    = b_sh_reg[0];
    assign d_bit    = x_bit ^ y_bit ^ br_reg;
    assign br_next  = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_reg);
    assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_bit = (state_reg == RUN) && (cnt_reg == LAST_BIT);

    // New bit enters at the MSB, so bit 0 lands at position 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = d_bit;
        end else begin : g_res_wn
            assign res_shift = {d_bit, res_reg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt_reg == LAST_BIT) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg <= '0;
            b_sh_reg <= '0;
            res_reg  <= '0;
            br_reg   <= 1'b0;
            cnt_reg  <= '0;
            diff_reg <= '0;
            bout_reg <= 1'b0;
        end else if (accept) begin
            a_sh_reg <= a;
            b_sh_reg <= b;
            br_reg   <= bin;
            res_reg  <= '0;
            cnt_reg  <= '0;
        end else if (state_reg == RUN) begin
            a_sh_reg <= a_sh_reg >> 1;
            b_sh_reg <= b_sh_reg >> 1;
            br_reg   <= br_next;
            res_reg  <= res_shift;
            cnt_reg  <= cnt_reg + 6'd1;
            if (last_bit) begin
                diff_reg <= res_shift;
                bout_reg <= br_next;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_reg, b_msb_reg, ovf_reg;

    // Operand sign bits are shifted out during RUN, so keep copies for the overflow test.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
        end else if (last_bit) begin
            ovf_reg <= (a_msb_reg != b_msb_reg) && (d_bit != a_msb_reg);
        end
    end

    assign ovf = ovf_reg;
`endif

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign diff = diff_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl: WIDTH=8 instance and WIDTH=1 instance
// sharing one clock and reset.
module tb_serial_subtractor_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, start1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       bin1 = 1'b0;
    logic       busy8, done8, bout8, busy1, done1, bout1;
    logic [7:0] diff8;
    logic [0:0] diff1;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf1;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Called at the negedge just after the accept edge; returns number of busy cycles.
    task automatic count_busy8(output int cyc);
        cyc = 0;
        while (busy8 && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic check_result8(input string tag, input logic [7:0] ediff,
                                 input logic ebout, input logic eovf);
        check({tag, " done"}, 32'(done8), 32'd1);
        check({tag, " diff"}, 32'(diff8), 32'(ediff));
        check({tag, " bout"}, 32'(bout8), 32'(ebout));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, " ovf"}, 32'(ovf8), 32'(eovf));
`else
        if (eovf !== eovf) check({tag, " ovf-x"}, 32'(eovf), 32'd0);
`endif
    endtask

    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tbin, input logic [7:0] ediff, input logic ebout,
                       input logic eovf);
        int cyc;
        @(negedge clk);
        a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        count_busy8(cyc);
        check({tag, " busy cycles"}, 32'(cyc), 32'd8);
        check_result8(tag, ediff, ebout, eovf);
        @(negedge clk);
        check({tag, " done pulse width"}, 32'(done8), 32'd0);
    endtask

    logic [1:0] exp1 [8];

    initial begin
        int cyc;
        int pulses;
        logic [7:0] seen_diff;
        exp1 = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", 32'(busy8), 32'd0);
        check("reset done", 32'(done8), 32'd0);
        check("reset diff", 32'(diff8), 32'd0);
        check("reset bout", 32'(bout8), 32'd0);

        op8("5-3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

        // Back-to-back: new start presented while the first result is in DONE.
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h05; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        count_busy8(cyc);
        check("3-5 busy cycles", 32'(cyc), 32'd8);
        check_result8("3-5", 8'hFE, 1'b1, 1'b0);
        a8 = 8'h00; b8 = 8'h00; bin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("b2b no idle busy", 32'(busy8), 32'd1);
        count_busy8(cyc);
        check("0-0-1 busy cycles", 32'(cyc), 32'd8);
        check_result8("0-0-1", 8'hFF, 1'b1, 1'b0);

        // start pulsed during RUN cycle 3 must be ignored.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        pulses = 0; seen_diff = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                pulses++;
                seen_diff = diff8;
                check("10-01 bout", 32'(bout8), 32'd0);
            end
            @(negedge clk);
        end
        check("10-01 done pulses", 32'(pulses), 32'd1);
        check("10-01 diff", 32'(seen_diff), 32'h0F);

        // Reset at RUN cycle 4 aborts with no done pulse.
        a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy8), 32'd0);
        check("abort done", 32'(done8), 32'd0);
        check("abort diff", 32'(diff8), 32'd0);
        check("abort bout", 32'(bout8), 32'd0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8 || busy8) pulses++;
            @(negedge clk);
        end
        check("abort no activity", 32'(pulses), 32'd0);

        op8("80-01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op8("5-3 again", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

        // WIDTH=1 truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            check($sformatf("w1 %b busy", v), 32'(busy1), 32'd1);
            @(negedge clk);
            check($sformatf("w1 %b done", v), 32'(done1), 32'd1);
            check($sformatf("w1 %b diff,bout", v), 32'({diff1, bout1}), 32'(exp1[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
